fwft_slice_reader: RTL and testbench

//  Sits directly downstream of async_fifo_fwft on its read-clock side. Pops wide FWFT

---
 rtl/fwft_slice_reader.sv | 87 ++++++++
 tb/tb_fwft_slice_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_slice_reader.sv
// Pops wide words from an FWFT FIFO and streams them out as narrow slices, LS slice first,
// for a programmed number of output words; unused slices of the final word are dropped.
module fwft_slice_reader #(
  parameter int unsigned C_IN_WIDTH  = 64,
  parameter int unsigned C_OUT_WIDTH = 16,
  parameter int unsigned C_LEN_BITS  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [C_IN_WIDTH-1:0]  FIFO_DATA,
  input  logic                   FIFO_EMPTY,
  output logic                   FIFO_RD_EN,
  input  logic                   XFER_START,
  input  logic [C_LEN_BITS-1:0]  XFER_LEN,
  output logic                   XFER_BUSY,
  output logic                   XFER_DONE,
  output logic [C_OUT_WIDTH-1:0] OUT_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   OUT_LAST
);

  localparam int unsigned C_RATIO = C_IN_WIDTH / C_OUT_WIDTH;
  localparam int unsigned IdxW    = (C_RATIO > 1) ? $clog2(C_RATIO) : 1;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [C_LEN_BITS-1:0] rem_q, rem_d;
  logic                  handshake, last_word, word_end;
  logic [C_IN_WIDTH-1:0] head_shifted;

  assign head_shifted = FIFO_DATA >> (C_OUT_WIDTH * 32'(idx_q));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    OUT_VALID  = (state_q == StXfer) & ~FIFO_EMPTY;
    OUT_DATA   = OUT_VALID ? head_shifted[C_OUT_WIDTH-1:0] : '0;
    last_word  = (rem_q == C_LEN_BITS'(1));
    word_end   = (idx_q == IdxW'(C_RATIO - 1));
    handshake  = OUT_VALID & OUT_READY;
    OUT_LAST   = OUT_VALID & last_word;
    // Popping on the final output word discards the rest of that FIFO word.
    FIFO_RD_EN = handshake & (word_end | last_word);
    XFER_BUSY  = (state_q == StXfer);
    XFER_DONE  = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (XFER_START) begin
          if (XFER_LEN != '0) begin
            state_d = StXfer;
            rem_d   = XFER_LEN;
            idx_d   = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StXfer: begin
        if (handshake) begin
          rem_d = rem_q - C_LEN_BITS'(1);
          idx_d = (word_end | last_word) ? '0 : idx_q + IdxW'(1);
          if (last_word) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_fwft_slice_reader.sv
// Bench for fwft_slice_reader: a queue-style FIFO model feeds the DUT; expected slices are
// derived from output-word index k as word k/RATIO, slice k%RATIO of the pushed sequence.
module tb_fwft_slice_reader;
  localparam int unsigned InW  = 64;
  localparam int unsigned OutW = 16;
  localparam int unsigned LenW = 16;
  localparam int          R    = InW / OutW;

  logic            CLK = 1'b0;
  logic            RST;
  logic [InW-1:0]  FIFO_DATA;
  logic            FIFO_EMPTY, FIFO_RD_EN;
  logic            XFER_START;
  logic [LenW-1:0] XFER_LEN;
  logic            XFER_BUSY, XFER_DONE;
  logic [OutW-1:0] OUT_DATA;
  logic            OUT_VALID, OUT_READY, OUT_LAST;

  int errors = 0;
  int checks = 0;

  logic [InW-1:0] mem [0:1023];
  int             wr_ptr = 0;
  int             rd_ptr = 0;
  int             exp_rd = 0;
  logic [InW-1:0] pend[$];
  logic           ready_pat[$];

  fwft_slice_reader #(
    .C_IN_WIDTH (InW),
    .C_OUT_WIDTH(OutW),
    .C_LEN_BITS (LenW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FIFO_DATA (FIFO_DATA),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RD_EN(FIFO_RD_EN),
    .XFER_START(XFER_START),
    .XFER_LEN  (XFER_LEN),
    .XFER_BUSY (XFER_BUSY),
    .XFER_DONE (XFER_DONE),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_LAST  (OUT_LAST)
  );

  always #5 CLK = ~CLK;

  assign FIFO_EMPTY = (wr_ptr == rd_ptr);
  assign FIFO_DATA  = FIFO_EMPTY ? '0 : mem[rd_ptr % 1024];

  always @(posedge CLK) if (FIFO_RD_EN && !FIFO_EMPTY) rd_ptr <= rd_ptr + 1;

  task automatic push(input logic [InW-1:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  // One transfer of len words; entered and left at posedge+1.
  task automatic run_stream(input int len, input int ready_pct, output int ncyc);
    int             k     = 0;
    int             stall = 0;
    int             base  = exp_rd;
    logic           hs, exp_rd_en, exp_last;
    logic [InW-1:0] w;
    logic [OutW-1:0] exp_d;
    ncyc       = 0;
    XFER_START = 1'b1;
    XFER_LEN   = LenW'(len);
    OUT_READY  = 1'b1;
    @(negedge CLK);
    checks++;
    if (XFER_BUSY !== 1'b0 || OUT_VALID !== 1'b0 || FIFO_RD_EN !== 1'b0 || XFER_DONE !== 1'b0) begin
      errors++;
      $display("FAIL idle_start: busy=%b valid=%b rd_en=%b done=%b, required all 0",
               XFER_BUSY, OUT_VALID, FIFO_RD_EN, XFER_DONE);
    end
    @(posedge CLK); #1;
    XFER_START = 1'b0;
    while (k < len && ncyc < 4000) begin
      ncyc++;
      if (ready_pat.size() > 0) OUT_READY = ready_pat.pop_front();
      else OUT_READY = ($urandom_range(99) < ready_pct);
      XFER_START = ($urandom_range(7) == 0);
      XFER_LEN   = LenW'($urandom);
      if (FIFO_EMPTY && pend.size() > 0) begin
        stall++;
        if (stall >= 3) begin
          push(pend.pop_front());
          stall = 0;
        end
      end
      @(negedge CLK);
      w         = mem[(base + k / R) % 1024];
      exp_d     = w[(k % R) * OutW +: OutW];
      exp_last  = (k == len - 1);
      hs        = !FIFO_EMPTY && OUT_READY;
      exp_rd_en = hs && ((k % R) == R - 1 || k == len - 1);
      checks++;
      if (OUT_VALID !== ~FIFO_EMPTY || XFER_BUSY !== 1'b1 || XFER_DONE !== 1'b0) begin
        errors++;
        $display("FAIL stream_ctl k=%0d: valid=%b busy=%b done=%b, required valid=%b busy=1 done=0",
                 k, OUT_VALID, XFER_BUSY, XFER_DONE, ~FIFO_EMPTY);
      end
      checks++;
      if (!FIFO_EMPTY) begin
        if (OUT_DATA !== exp_d || OUT_LAST !== exp_last || FIFO_RD_EN !== exp_rd_en) begin
          errors++;
          $display("FAIL stream_data k=%0d: data=%h last=%b rd_en=%b, required data=%h last=%b rd_en=%b",
                   k, OUT_DATA, OUT_LAST, FIFO_RD_EN, exp_d, exp_last, exp_rd_en);
        end
      end else if (OUT_DATA !== '0 || OUT_LAST !== 1'b0 || FIFO_RD_EN !== 1'b0) begin
        errors++;
        $display("FAIL stream_empty k=%0d: data=%h last=%b rd_en=%b, required 0 0 0",
                 k, OUT_DATA, OUT_LAST, FIFO_RD_EN);
      end
      if (hs) k++;
      @(posedge CLK); #1;
    end
    checks++;
    if (k < len) begin
      errors++;
      $display("FAIL stream_timeout: handshakes=%0d, required %0d", k, len);
    end
    exp_rd     = base + (len + R - 1) / R;
    // A start request during the done cycle must be ignored.
    XFER_START = 1'b1;
    XFER_LEN   = LenW'(3);
    @(negedge CLK);
    checks++;
    if (XFER_DONE !== 1'b1 || XFER_BUSY !== 1'b0 || OUT_VALID !== 1'b0 || FIFO_RD_EN !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b valid=%b rd_en=%b, required 1 0 0 0",
               XFER_DONE, XFER_BUSY, OUT_VALID, FIFO_RD_EN);
    end
    @(posedge CLK); #1;
    XFER_START = 1'b0;
    @(negedge CLK);
    checks++;
    if (XFER_DONE !== 1'b0 || XFER_BUSY !== 1'b0 || rd_ptr !== exp_rd) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b pops=%0d, required 0 0 %0d",
               XFER_DONE, XFER_BUSY, rd_ptr, exp_rd);
    end
    @(posedge CLK); #1;
    ready_pat.delete();
  endtask

  task automatic test_reset;
    RST = 1'b1; XFER_START = 1'b0; XFER_LEN = '0; OUT_READY = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || OUT_DATA !== '0 || OUT_LAST !== 1'b0 || FIFO_RD_EN !== 1'b0 ||
        XFER_BUSY !== 1'b0 || XFER_DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h last=%b rd_en=%b busy=%b done=%b, required all 0",
               OUT_VALID, OUT_DATA, OUT_LAST, FIFO_RD_EN, XFER_BUSY, XFER_DONE);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    push(64'h0004_0003_0002_0001);
    ready_pat = {1'b1, 1'b1, 1'b1, 1'b1};
    run_stream(4, 100, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL basic_cycles: cycles=%0d, required 4", n);
    end
  endtask

  task automatic test_multi_word;
    int n;
    push(64'h0004_0003_0002_0001);
    push(64'h0008_0007_0006_0005);
    push({$urandom, $urandom});
    run_stream(6, 100, n);
    run_stream(1, 100, n);
  endtask

  task automatic test_backpressure;
    int n;
    push({$urandom, $urandom});
    ready_pat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_stream(4, 0, n);
    checks++;
    if (n !== 7) begin
      errors++;
      $display("FAIL backpressure_cycles: cycles=%0d, required 7", n);
    end
  endtask

  task automatic test_underflow;
    int n;
    push({$urandom, $urandom});
    pend.push_back({$urandom, $urandom});
    run_stream(8, 100, n);
  endtask

  task automatic test_zero_len;
    int n;
    push({$urandom, $urandom});
    run_stream(0, 100, n);
    run_stream(1, 100, n);
  endtask

  task automatic test_reset_mid_word;
    int             n;
    logic [InW-1:0] w;
    w = {$urandom, $urandom};
    push(w);
    XFER_START = 1'b1; XFER_LEN = LenW'(4); OUT_READY = 1'b1;
    @(posedge CLK); #1;
    XFER_START = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== w[s * OutW +: OutW] || FIFO_RD_EN !== 1'b0) begin
        errors++;
        $display("FAIL pre_reset s=%0d: valid=%b data=%h rd_en=%b, required 1 %h 0",
                 s, OUT_VALID, OUT_DATA, FIFO_RD_EN, w[s * OutW +: OutW]);
      end
      @(posedge CLK); #1;
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || OUT_DATA !== '0 || OUT_LAST !== 1'b0 || FIFO_RD_EN !== 1'b0 ||
        XFER_BUSY !== 1'b0 || XFER_DONE !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h last=%b rd_en=%b busy=%b done=%b, required all 0",
               OUT_VALID, OUT_DATA, OUT_LAST, FIFO_RD_EN, XFER_BUSY, XFER_DONE);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (XFER_DONE !== 1'b0 || XFER_BUSY !== 1'b0 || OUT_VALID !== 1'b0 || rd_ptr !== exp_rd) begin
      errors++;
      $display("FAIL post_reset: done=%b busy=%b valid=%b pops=%0d, required 0 0 0 %0d",
               XFER_DONE, XFER_BUSY, OUT_VALID, rd_ptr, exp_rd);
    end
    @(posedge CLK); #1;
    run_stream(2, 100, n);
  endtask

  task automatic test_random;
    int n, len, words;
    for (int t = 0; t < 25; t++) begin
      len   = $urandom_range(0, 13);
      words = (len + R - 1) / R;
      for (int i = 0; i < words; i++) begin
        if (i > 0 && $urandom_range(2) == 0) pend.push_back({$urandom, $urandom});
        else if (pend.size() == 0) push({$urandom, $urandom});
        else pend.push_back({$urandom, $urandom});
      end
      run_stream(len, $urandom_range(30, 100), n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_word();
    test_backpressure();
    test_underflow();
    test_zero_len();
    test_reset_mid_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
